// File: rtl/jc_pkg.sv
// rtl/jc_pkg.sv - shared types and Johnson-code index helper for johnson_phase_decoder
package jc_pkg;

   // Default Johnson code width and the widest code the helper function can handle
   localparam int JC_WIDTH     = 4;
   localparam int JC_MAX_WIDTH = 16;

   // Lock state machine states
   typedef enum logic [1:0] {
      INIT = 2'd0,
      ACQ  = 2'd1,
      LOCK = 2'd2
   } jc_state_e;

   // Decoded code: binary index (wide enough for 2*JC_MAX_WIDTH-1) plus legality flag
   typedef struct packed {
      logic [4:0] idx;
      logic       legal;
   } jc_dec_t;

   // Map a twisted-ring code of the given width to its index and flag whether the
   // code is the canonical one for that index (anything else is a corrupted ring).
   function automatic jc_dec_t jc_idx(input logic [JC_MAX_WIDTH-1:0] code, input int width);
      jc_dec_t                 r;
      int                      ones;
      int                      idx;
      logic [JC_MAX_WIDTH-1:0] mask;
      logic [JC_MAX_WIDTH-1:0] canon;
      ones = 0;
      for (int k = 0; k < JC_MAX_WIDTH; k++) begin
         if (k < width && code[k]) begin
            ones++;
         end
      end
      // The upper half of the sequence has the MSB set and loses ones from the bottom
      if (code[width-1]) begin
         idx = 2 * width - ones;
      end else begin
         idx = ones;
      end
      mask = JC_MAX_WIDTH'((32'd1 << width) - 32'd1);
      if (idx <= width) begin
         canon = JC_MAX_WIDTH'((32'd1 << idx) - 32'd1);
      end else begin
         canon = mask & ~JC_MAX_WIDTH'((32'd1 << (idx - width)) - 32'd1);
      end
      r.idx   = 5'(idx);
      r.legal = ((code & mask) == canon);
      return r;
   endfunction

endpackage

// File: rtl/jc_code_decode.sv
// rtl/jc_code_decode.sv - combinational Johnson code to phase index decoder with legality flag
module jc_code_decode
   import jc_pkg::*;
#(
   parameter  int WIDTH = JC_WIDTH,
   localparam int PW    = $clog2(2 * WIDTH)
) (
   input  logic [WIDTH-1:0] code_i,
   output logic [PW-1:0]    idx_o,
   output logic             legal_o
);

   jc_dec_t dec;

   // Decode the raw ring bits; the index is only meaningful when legal_o is set
   always_comb begin
      dec     = jc_idx(JC_MAX_WIDTH'(code_i), WIDTH);
      idx_o   = PW'(dec.idx);
      legal_o = dec.legal;
   end

endmodule

// File: rtl/johnson_phase_decoder.sv
// rtl/johnson_phase_decoder.sv - Johnson code phase decoder with lock FSM and revolution counter (optional JCDEC_REVERSE_EN)
module johnson_phase_decoder
   import jc_pkg::*;
#(
   parameter  int WIDTH      = JC_WIDTH,
   parameter  int LOCK_STEPS = 3,
   parameter  int REV_W      = 8,
   localparam int PW         = $clog2(2 * WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] i,
   output logic [PW-1:0]    phase,
   output logic             code_ok,
   output logic             step,
   output logic             hold,
   output logic             err,
   output logic             locked,
   output logic [REV_W-1:0] rev_cnt
);

   localparam logic [PW-1:0] LAST = PW'(2 * WIDTH - 1);

   jc_state_e        state_q, state_d;
   logic [3:0]       good_q, good_d;
   logic [WIDTH-1:0] prev_q, prev_d;
   logic [PW-1:0]    phase_q, phase_d;
   logic [REV_W-1:0] rev_q, rev_d;
   logic             code_ok_q, code_ok_d;
   logic             step_q, step_d;
   logic             hold_q, hold_d;
   logic             err_q, err_d;

   logic [PW-1:0]    dec_idx;
   logic             dec_legal;
   logic [PW-1:0]    fwd_idx;
   logic             is_fwd;
   logic             is_step;
   logic             is_hold;
   logic [3:0]       good_inc;
`ifdef JCDEC_REVERSE_EN
   logic [PW-1:0]    bwd_idx;
   logic             is_bwd;
`endif

   jc_code_decode #(
      .WIDTH (WIDTH)
   ) u_dec (
      .code_i  (i),
      .idx_o   (dec_idx),
      .legal_o (dec_legal)
   );

   // Classify the incoming index relative to the last accepted phase
   always_comb begin
      fwd_idx  = (phase_q == LAST) ? '0 : phase_q + PW'(1);
      is_fwd   = (dec_idx == fwd_idx);
      is_hold  = (i == prev_q);
      good_inc = good_q + 4'd1;
`ifdef JCDEC_REVERSE_EN
      bwd_idx  = (phase_q == '0) ? LAST : phase_q - PW'(1);
      is_bwd   = (dec_idx == bwd_idx);
      is_step  = is_fwd | is_bwd;
`else
      is_step  = is_fwd;
`endif
   end

   // Next-state logic for the lock FSM, phase tracking, pulses and revolution counter
   always_comb begin
      state_d   = state_q;
      good_d    = good_q;
      prev_d    = prev_q;
      phase_d   = phase_q;
      rev_d     = rev_q;
      code_ok_d = dec_legal;
      step_d    = 1'b0;
      hold_d    = 1'b0;
      err_d     = 1'b0;
      if (!dec_legal) begin
         // A corrupted code means the ring can no longer be trusted; restart from scratch
         err_d   = 1'b1;
         state_d = INIT;
      end else begin
         phase_d = dec_idx;
         prev_d  = i;
         case (state_q)
            INIT: begin
               state_d = ACQ;
               good_d  = 4'd0;
            end
            ACQ: begin
               if (is_step) begin
                  step_d = 1'b1;
                  good_d = good_inc;
                  if (good_inc >= 4'(LOCK_STEPS)) begin
                     state_d = LOCK;
                  end
               end else if (is_hold) begin
                  hold_d = 1'b1;
               end else begin
                  err_d  = 1'b1;
                  good_d = 4'd0;
               end
            end
            LOCK: begin
               if (is_step) begin
                  step_d = 1'b1;
                  if (is_fwd && phase_q == LAST) begin
                     rev_d = rev_q + REV_W'(1);
                  end
`ifdef JCDEC_REVERSE_EN
                  if (is_bwd && phase_q == '0) begin
                     rev_d = rev_q - REV_W'(1);
                  end
`endif
               end else if (is_hold) begin
                  hold_d = 1'b1;
               end else begin
                  err_d   = 1'b1;
                  good_d  = 4'd0;
                  state_d = ACQ;
               end
            end
            default: begin
               state_d = INIT;
               good_d  = 4'd0;
            end
         endcase
      end
   end

   // Register all state and outputs; reset has priority over any input event
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= INIT;
         good_q    <= 4'd0;
         prev_q    <= '0;
         phase_q   <= '0;
         rev_q     <= '0;
         code_ok_q <= 1'b0;
         step_q    <= 1'b0;
         hold_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         good_q    <= good_d;
         prev_q    <= prev_d;
         phase_q   <= phase_d;
         rev_q     <= rev_d;
         code_ok_q <= code_ok_d;
         step_q    <= step_d;
         hold_q    <= hold_d;
         err_q     <= err_d;
      end
   end

   assign phase   = phase_q;
   assign code_ok = code_ok_q;
   assign step    = step_q;
   assign hold    = hold_q;
   assign err     = err_q;
   assign locked  = (state_q == LOCK);
   assign rev_cnt = rev_q;

endmodule

// File: tb/tb_johnson_phase_decoder.sv
// tb/tb_johnson_phase_decoder.sv - scoreboard testbench for johnson_phase_decoder
module tb_johnson_phase_decoder;

   logic       clk;
   logic       rst;
   logic [3:0] i;
   logic [2:0] phase;
   logic       code_ok;
   logic       step;
   logic       hold;
   logic       err;
   logic       locked;
   logic [7:0] rev_cnt;
   logic [15:0] obs;

   int errors;
   int checks;
   logic [15:0] exp_q[$];
   logic [3:0]  jc [8];

   johnson_phase_decoder #(
      .WIDTH      (4),
      .LOCK_STEPS (3),
      .REV_W      (8)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .i       (i),
      .phase   (phase),
      .code_ok (code_ok),
      .step    (step),
      .hold    (hold),
      .err     (err),
      .locked  (locked),
      .rev_cnt (rev_cnt)
   );

   assign obs = {phase, code_ok, step, hold, err, locked, rev_cnt};

   always #5 clk = ~clk;

   function automatic logic [15:0] pk(input int ph, input bit ok, input bit st, input bit ho,
                                      input bit er, input bit lk, input int rv);
      return {3'(ph), ok, st, ho, er, lk, 8'(rv)};
   endfunction

   task automatic test_reset();
      logic [15:0] e;
      rst = 1'b1;
      i   = 4'b1111;
      for (int n = 0; n < 2; n++) begin
         exp_q.push_back(16'h0000);
         @(posedge clk); #1;
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL reset[%0d] got %h want %h", n, obs, e);
         end
      end
      rst = 1'b0;
   endtask

   task automatic test_acquire();
      logic [3:0]  codes [4];
      logic [15:0] exps [4];
      logic [15:0] e;
      codes = '{4'b0000, 4'b0001, 4'b0011, 4'b0111};
      exps[0] = pk(0, 1, 0, 0, 0, 0, 0);
      exps[1] = pk(1, 1, 1, 0, 0, 0, 0);
      exps[2] = pk(2, 1, 1, 0, 0, 0, 0);
      exps[3] = pk(3, 1, 1, 0, 0, 1, 0);
      for (int n = 0; n < 4; n++) begin
         i = codes[n];
         exp_q.push_back(exps[n]);
         @(posedge clk); #1;
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL acquire[%0d] got %h want %h", n, obs, e);
         end
      end
   endtask

   task automatic test_revolution();
      logic [3:0]  codes [5];
      logic [15:0] exps [5];
      logic [15:0] e;
      codes = '{4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
      exps[0] = pk(4, 1, 1, 0, 0, 1, 0);
      exps[1] = pk(5, 1, 1, 0, 0, 1, 0);
      exps[2] = pk(6, 1, 1, 0, 0, 1, 0);
      exps[3] = pk(7, 1, 1, 0, 0, 1, 0);
      exps[4] = pk(0, 1, 1, 0, 0, 1, 1);
      for (int n = 0; n < 5; n++) begin
         i = codes[n];
         exp_q.push_back(exps[n]);
         @(posedge clk); #1;
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL revolution[%0d] got %h want %h", n, obs, e);
         end
      end
   endtask

   task automatic test_illegal_in_lock();
      logic [3:0]  codes [2];
      logic [15:0] exps [2];
      logic [15:0] e;
      codes = '{4'b0101, 4'b0011};
      exps[0] = pk(0, 0, 0, 0, 1, 0, 1);
      exps[1] = pk(2, 1, 0, 0, 0, 0, 1);
      for (int n = 0; n < 2; n++) begin
         i = codes[n];
         exp_q.push_back(exps[n]);
         @(posedge clk); #1;
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL illegal_in_lock[%0d] got %h want %h", n, obs, e);
         end
      end
   endtask

   // Jump in ACQ, hold, then relock; the wrap that achieves lock must not count
   task automatic test_jump_in_acq();
      logic [3:0]  codes [7];
      logic [15:0] exps [7];
      logic [15:0] e;
      codes = '{4'b1110, 4'b1110, 4'b1100, 4'b1000, 4'b0000, 4'b0000, 4'b0001};
      exps[0] = pk(5, 1, 0, 0, 1, 0, 1);
      exps[1] = pk(5, 1, 0, 1, 0, 0, 1);
      exps[2] = pk(6, 1, 1, 0, 0, 0, 1);
      exps[3] = pk(7, 1, 1, 0, 0, 0, 1);
      exps[4] = pk(0, 1, 1, 0, 0, 1, 1);
      exps[5] = pk(0, 1, 0, 1, 0, 1, 1);
      exps[6] = pk(1, 1, 1, 0, 0, 1, 1);
      for (int n = 0; n < 7; n++) begin
         i = codes[n];
         exp_q.push_back(exps[n]);
         @(posedge clk); #1;
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL jump_in_acq[%0d] got %h want %h", n, obs, e);
         end
      end
   endtask

   // Backward steps from LOCK at phase 1: 1->0 then 0->7
   task automatic test_reverse_step();
      logic [3:0]  codes [2];
      logic [15:0] exps [2];
      logic [15:0] e;
      codes = '{4'b0000, 4'b1000};
`ifdef JCDEC_REVERSE_EN
      exps[0] = pk(0, 1, 1, 0, 0, 1, 1);
      exps[1] = pk(7, 1, 1, 0, 0, 1, 0);
`else
      exps[0] = pk(0, 1, 0, 0, 1, 0, 1);
      exps[1] = pk(7, 1, 0, 0, 1, 0, 1);
`endif
      for (int n = 0; n < 2; n++) begin
         i = codes[n];
         exp_q.push_back(exps[n]);
         @(posedge clk); #1;
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL reverse_step[%0d] got %h want %h", n, obs, e);
         end
      end
   endtask

   // Reach LOCK with rev_cnt=1, then reset on the same edge as a legal step
   task automatic test_mid_reset();
      logic [3:0]  codes [5];
      logic [15:0] exps [5];
      logic [15:0] e;
      codes = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b0101};
`ifdef JCDEC_REVERSE_EN
      exps[0] = pk(0, 1, 1, 0, 0, 1, 1);
      exps[1] = pk(1, 1, 1, 0, 0, 1, 1);
`else
      exps[0] = pk(0, 1, 1, 0, 0, 0, 1);
      exps[1] = pk(1, 1, 1, 0, 0, 0, 1);
`endif
      exps[2] = pk(2, 1, 1, 0, 0, 1, 1);
      exps[3] = 16'h0000;
      exps[4] = pk(0, 0, 0, 0, 1, 0, 0);
      for (int n = 0; n < 5; n++) begin
         i   = codes[n];
         rst = (n == 3);
         exp_q.push_back(exps[n]);
         @(posedge clk); #1;
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL mid_reset[%0d] got %h want %h", n, obs, e);
         end
      end
      rst = 1'b0;
   endtask

   // Lock from INIT, then run 256 revolutions so rev_cnt wraps back to 0
   task automatic test_rev_wrap();
      logic [15:0] e;
      int          p;
      int          rv;
      for (int n = 0; n < 4; n++) begin
         i = jc[n];
         exp_q.push_back(pk(n, 1, (n != 0), 0, 0, (n == 3), 0));
         @(posedge clk); #1;
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL wrap_lock[%0d] got %h want %h", n, obs, e);
         end
      end
      rv = 0;
      for (int n = 0; n < 2048; n++) begin
         p = (4 + n) % 8;
         if (p == 0) begin
            rv = (rv + 1) % 256;
         end
         i = jc[p];
         exp_q.push_back(pk(p, 1, 1, 0, 0, 1, rv));
         @(posedge clk); #1;
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL rev_wrap[%0d] got %h want %h", n, obs, e);
         end
      end
   endtask

   initial begin
      clk    = 1'b0;
      rst    = 1'b1;
      i      = 4'b1111;
      errors = 0;
      checks = 0;
      jc[0] = 4'b0000; jc[1] = 4'b0001; jc[2] = 4'b0011; jc[3] = 4'b0111;
      jc[4] = 4'b1111; jc[5] = 4'b1110; jc[6] = 4'b1100; jc[7] = 4'b1000;
      test_reset();
      test_acquire();
      test_revolution();
      test_illegal_in_lock();
      test_jump_in_acq();
      test_reverse_step();
      test_mid_reset();
      test_rev_wrap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
